hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-control unit for the 5-stage MIPS core, replacing the purely combinational hazard unit. It covers everything the old unit did: E-stage forwarding from M/W, D-stage branch forwarding, load-use stalls and branch stalls. It adds three things: a handshake FSM that holds the pipeline for the multi-cycle mult/div unit, an exception flush from M with top priority, and a saturating stall-cycle performance counter. It sits beside the datapath and drives every pipeline-register enable and clear.

---
 rtl/hazard_pkg.sv | 8 +
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/div_stall_fsm.sv | 45 ++++
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/pipeline-control unit.
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} div_state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard unit signal bundle; master is the datapath side.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) ();
  logic [REG_AW-1:0] rsD, rtD;
  logic              branchD;
  logic [REG_AW-1:0] rsE, rtE, writeRegE;
  logic              regWriteE, memToRegE, divStartE, divDoneE;
  logic [REG_AW-1:0] writeRegM;
  logic              regWriteM, memToRegM, excM;
  logic [REG_AW-1:0] writeRegW;
  logic              regWriteW;

  logic              stallF, stallD, stallE;
  logic              flushD, flushE, flushM;
  logic              forwardAD, forwardBD;
  logic [1:0]        forwardAE, forwardBE;
  logic              divAbort, divBusy;
  logic [CNT_W-1:0]  stallCount;

  modport master (
    output rsD, rtD, branchD, rsE, rtE, writeRegE, regWriteE, memToRegE,
           divStartE, divDoneE, writeRegM, regWriteM, memToRegM, excM,
           writeRegW, regWriteW,
    input  stallF, stallD, stallE, flushD, flushE, flushM, forwardAD,
           forwardBD, forwardAE, forwardBE, divAbort, divBusy, stallCount
  );

  modport slave (
    input  rsD, rtD, branchD, rsE, rtE, writeRegE, regWriteE, memToRegE,
           divStartE, divDoneE, writeRegM, regWriteM, memToRegM, excM,
           writeRegW, regWriteW,
    output stallF, stallD, stallE, flushD, flushE, flushM, forwardAD,
           forwardBD, forwardAE, forwardBE, divAbort, divBusy, stallCount
  );
endinterface

// File: rtl/div_stall_fsm.sv
// Holds the pipeline while the multi-cycle mult/div unit is working.
//   state | meaning
//   IDLE  | no mult/div in flight; a start in E stalls and enters BUSY
//   BUSY  | mult/div in flight; stall until done pulse, exception aborts
module div_stall_fsm
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_done,
  input  logic i_exc,
  output logic o_div_stall,
  output logic o_div_abort,
  output logic o_busy
);
  div_state_e r_state;
  div_state_e w_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_div_stall = 1'b0;
    o_div_abort = 1'b0;
    case (r_state)
      IDLE: begin
        o_div_stall = i_start;
        o_div_abort = i_exc && i_start;
        if (i_start && !i_exc) w_next = BUSY;
      end
      BUSY: begin
        o_div_stall = !i_done;
        o_div_abort = i_exc;
        if (i_done || i_exc) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_busy = (r_state == BUSY);
endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use/branch stalls, mult/div hold, exception flush and
// a saturating stall-cycle counter for the 5-stage pipeline.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);
  logic             w_lw_stall, w_br_stall;
  logic             w_div_stall, w_div_abort, w_div_busy;
  logic             w_stall_f, w_stall_d, w_stall_e;
  logic             w_flush_d, w_flush_e, w_flush_m;
  logic [CNT_W-1:0] r_stall_cnt;

  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] wm,
                                       input logic              rwm,
                                       input logic [REG_AW-1:0] ww,
                                       input logic              rww);
    if (src != REG_AW'(0) && src == wm && rwm) return FWD_M;
    if (src != REG_AW'(0) && src == ww && rww) return FWD_W;
    return FWD_RF;
  endfunction

  assign bus.forwardAE = fwd_e(bus.rsE, bus.writeRegM, bus.regWriteM,
                               bus.writeRegW, bus.regWriteW);
  assign bus.forwardBE = fwd_e(bus.rtE, bus.writeRegM, bus.regWriteM,
                               bus.writeRegW, bus.regWriteW);
  assign bus.forwardAD = (bus.rsD != REG_AW'(0)) && (bus.rsD == bus.writeRegM)
                         && bus.regWriteM;
  assign bus.forwardBD = (bus.rtD != REG_AW'(0)) && (bus.rtD == bus.writeRegM)
                         && bus.regWriteM;

  assign w_lw_stall = bus.memToRegE && (bus.writeRegE != REG_AW'(0)) &&
                      ((bus.writeRegE == bus.rsD) || (bus.writeRegE == bus.rtD));

  assign w_br_stall = bus.branchD && (
      (bus.regWriteE && (bus.writeRegE != REG_AW'(0)) &&
       ((bus.writeRegE == bus.rsD) || (bus.writeRegE == bus.rtD))) ||
      (bus.memToRegM && (bus.writeRegM != REG_AW'(0)) &&
       ((bus.writeRegM == bus.rsD) || (bus.writeRegM == bus.rtD))));

  div_stall_fsm u_div_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_start     (bus.divStartE),
    .i_done      (bus.divDoneE),
    .i_exc       (bus.excM),
    .o_div_stall (w_div_stall),
    .o_div_abort (w_div_abort),
    .o_busy      (w_div_busy)
  );

  // Reset behaves like a full flush so no stale instruction survives it.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_m = 1'b0;
    if (rst || bus.excM) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
      w_flush_m = 1'b1;
    end else if (w_div_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_flush_m = 1'b1;
    end else if (w_lw_stall || w_br_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_stall_f && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign bus.stallF     = w_stall_f;
  assign bus.stallD     = w_stall_d;
  assign bus.stallE     = w_stall_e;
  assign bus.flushD     = w_flush_d;
  assign bus.flushE     = w_flush_e;
  assign bus.flushM     = w_flush_m;
  assign bus.divAbort   = w_div_abort && !rst;
  assign bus.divBusy    = w_div_busy;
  assign bus.stallCount = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector scoreboard bench for hazard_ctrl (4-bit stall counter).
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk;
  logic rst;

  hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rsD, rtD;
    logic          branchD;
    logic [AW-1:0] rsE, rtE, writeRegE;
    logic          regWriteE, memToRegE, divStartE, divDoneE;
    logic [AW-1:0] writeRegM;
    logic          regWriteM, memToRegM, excM;
    logic [AW-1:0] writeRegW;
    logic          regWriteW;
    logic          rst;
  } vin_t;

  // ctl = {stallF, stallD, stallE, flushD, flushE, flushM}
  typedef struct {
    string      name;
    logic [5:0] ctl;
    logic [1:0] fae, fbe;
    logic       fad, fbd, abort;
    int         busy;
    int         cnt;
  } vexp_t;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_FLSH = 6'b000111;
  localparam logic [5:0] C_LW   = 6'b110010;
  localparam logic [5:0] C_DIV  = 6'b111001;

  vexp_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic vin_t zin();
    vin_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vexp_t mk(string n, logic [5:0] c, logic [1:0] ae,
                               logic [1:0] be, logic ad, logic bd,
                               logic ab, int busy, int cnt);
    vexp_t e;
    e.name = n; e.ctl = c; e.fae = ae; e.fbe = be; e.fad = ad; e.fbd = bd;
    e.abort = ab; e.busy = busy; e.cnt = cnt;
    return e;
  endfunction

  task automatic step(input vin_t v, input vexp_t e);
    @(posedge clk);
    #1;
    rst           = v.rst;
    bus.rsD       = v.rsD;       bus.rtD       = v.rtD;
    bus.branchD   = v.branchD;
    bus.rsE       = v.rsE;       bus.rtE       = v.rtE;
    bus.writeRegE = v.writeRegE; bus.regWriteE = v.regWriteE;
    bus.memToRegE = v.memToRegE; bus.divStartE = v.divStartE;
    bus.divDoneE  = v.divDoneE;
    bus.writeRegM = v.writeRegM; bus.regWriteM = v.regWriteM;
    bus.memToRegM = v.memToRegM; bus.excM      = v.excM;
    bus.writeRegW = v.writeRegW; bus.regWriteW = v.regWriteW;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vexp_t e;
      logic [5:0] ctl;
      logic [5:0] fwd;
      e   = exp_q.pop_front();
      ctl = {bus.stallF, bus.stallD, bus.stallE, bus.flushD, bus.flushE, bus.flushM};
      fwd = {bus.forwardAE, bus.forwardBE, bus.forwardAD, bus.forwardBD};
      checks++;
      if (ctl !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %b exp %b", e.name, ctl, e.ctl);
      end
      checks++;
      if (fwd !== {e.fae, e.fbe, e.fad, e.fbd}) begin
        errors++;
        $display("FAIL %s fwd got %b exp %b", e.name, fwd, {e.fae, e.fbe, e.fad, e.fbd});
      end
      checks++;
      if (bus.divAbort !== e.abort) begin
        errors++;
        $display("FAIL %s divAbort got %b exp %b", e.name, bus.divAbort, e.abort);
      end
      if (e.busy >= 0) begin
        checks++;
        if (bus.divBusy !== 1'(e.busy)) begin
          errors++;
          $display("FAIL %s divBusy got %b exp %0d", e.name, bus.divBusy, e.busy);
        end
      end
      if (e.cnt >= 0) begin
        checks++;
        if (int'(bus.stallCount) != e.cnt) begin
          errors++;
          $display("FAIL %s stallCount got %0d exp %0d", e.name, bus.stallCount, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vin_t v;
    rst = 1'b1;
    v = zin(); v.rst = 1'b1;
    step(v, mk("rst0", C_FLSH, 2'b00, 2'b00, 0, 0, 0, -1, -1));
    step(v, mk("rst1", C_FLSH, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    v = zin();
    step(v, mk("idle", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 0));

    // forwarding
    v = zin(); v.rsE = 3; v.rtE = 3; v.writeRegM = 3; v.writeRegW = 3;
    v.regWriteM = 1; v.regWriteW = 1; v.rsD = 3; v.rtD = 3;
    step(v, mk("fwd_m_prio", C_NONE, 2'b10, 2'b10, 1, 1, 0, 0, 0));
    v = zin(); v.rsE = 3; v.rtE = 7; v.writeRegM = 3; v.writeRegW = 7;
    v.regWriteM = 1; v.regWriteW = 1; v.rsD = 3; v.rtD = 7;
    step(v, mk("fwd_mix", C_NONE, 2'b10, 2'b01, 1, 0, 0, 0, 0));
    v = zin(); v.regWriteM = 1; v.regWriteW = 1;
    step(v, mk("fwd_r0", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    v = zin(); v.rsE = 5; v.rtE = 5; v.rsD = 5; v.writeRegM = 5;
    v.writeRegW = 5; v.regWriteW = 1;
    step(v, mk("fwd_w_only", C_NONE, 2'b01, 2'b01, 0, 0, 0, 0, 0));

    // load-use and branch stalls
    v = zin(); v.memToRegE = 1; v.regWriteE = 1; v.writeRegE = 8; v.rtD = 8;
    step(v, mk("lw_use", C_LW, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    v = zin();
    step(v, mk("lw_after", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    v = zin(); v.memToRegE = 1; v.regWriteE = 1;
    step(v, mk("lw_r0", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    v = zin(); v.branchD = 1; v.rsD = 4; v.regWriteE = 1; v.writeRegE = 4;
    step(v, mk("br_e", C_LW, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    v = zin();
    step(v, mk("br_after", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 2));
    v = zin(); v.branchD = 1; v.rtD = 6; v.memToRegM = 1; v.writeRegM = 6;
    v.regWriteM = 1;
    step(v, mk("br_m_load", C_LW, 2'b00, 2'b00, 0, 1, 0, 0, 2));
    v = zin(); v.branchD = 1; v.rsD = 4; v.writeRegE = 4;
    step(v, mk("br_noreg", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 3));

    v = zin(); v.rst = 1;
    step(v, mk("rst_mid", C_FLSH, 2'b00, 2'b00, 0, 0, 0, 0, 3));
    v = zin();
    step(v, mk("rst_clr", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 0));

    // mult/div: done four cycles after entering BUSY
    v = zin(); v.divStartE = 1;
    step(v, mk("div_start", C_DIV, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 4; i++)
      step(v, mk("div_busy", C_DIV, 2'b00, 2'b00, 0, 0, 0, 1, i));
    v.divDoneE = 1;
    step(v, mk("div_done", C_NONE, 2'b00, 2'b00, 0, 0, 0, 1, 5));
    v = zin(); v.divStartE = 1;
    step(v, mk("div_b2b", C_DIV, 2'b00, 2'b00, 0, 0, 0, 0, 5));
    v.divDoneE = 1;
    step(v, mk("div_b2b_done", C_NONE, 2'b00, 2'b00, 0, 0, 0, 1, 6));
    v = zin();
    step(v, mk("div_idle", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 6));

    // exceptions
    v = zin(); v.divStartE = 1;
    step(v, mk("exc_pre", C_DIV, 2'b00, 2'b00, 0, 0, 0, 0, 6));
    v.excM = 1;
    step(v, mk("exc_busy", C_FLSH, 2'b00, 2'b00, 0, 0, 1, 1, 7));
    v = zin();
    step(v, mk("exc_busy_nx", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 7));
    v = zin(); v.divStartE = 1;
    step(v, mk("exd_pre", C_DIV, 2'b00, 2'b00, 0, 0, 0, 0, 7));
    v.divDoneE = 1; v.excM = 1;
    step(v, mk("exc_done", C_FLSH, 2'b00, 2'b00, 0, 0, 1, 1, 8));
    v = zin();
    step(v, mk("exc_done_nx", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 8));
    v = zin(); v.divStartE = 1; v.excM = 1;
    step(v, mk("exc_idle_start", C_FLSH, 2'b00, 2'b00, 0, 0, 1, 0, 8));
    v = zin(); v.excM = 1;
    step(v, mk("exc_plain", C_FLSH, 2'b00, 2'b00, 0, 0, 0, 0, 8));

    // load-use coinciding with mult/div
    v = zin(); v.divStartE = 1; v.memToRegE = 1; v.regWriteE = 1;
    v.writeRegE = 8; v.rtD = 8;
    step(v, mk("sim_div_lw", C_DIV, 2'b00, 2'b00, 0, 0, 0, 0, 8));
    v.divDoneE = 1;
    step(v, mk("sim_release", C_LW, 2'b00, 2'b00, 0, 0, 0, 1, 9));
    v = zin();
    step(v, mk("sim_idle", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 10));

    // reset while BUSY: no abort, back to IDLE
    v = zin(); v.divStartE = 1;
    step(v, mk("rb_start", C_DIV, 2'b00, 2'b00, 0, 0, 0, 0, 10));
    v.rst = 1;
    step(v, mk("rb_rst", C_FLSH, 2'b00, 2'b00, 0, 0, 0, 1, 11));
    v = zin();
    step(v, mk("rb_after", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 0));

    // saturation of the 4-bit counter
    v = zin(); v.memToRegE = 1; v.writeRegE = 9; v.rsD = 9;
    for (int i = 0; i < 20; i++)
      step(v, mk("sat", C_LW, 2'b00, 2'b00, 0, 0, 0, 0, (i > 15) ? 15 : i));
    v = zin();
    step(v, mk("sat_end", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 15));
    v.rst = 1;
    step(v, mk("sat_rst", C_FLSH, 2'b00, 2'b00, 0, 0, 0, 0, 15));
    v = zin();
    step(v, mk("sat_clr", C_NONE, 2'b00, 2'b00, 0, 0, 0, 0, 0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain queue got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
